// File: rtl/debug_pkg.sv
// Shared types and constants for the debug frame transmitter.
// Holds the TX state enum, word/byte widths, default header and frame length.
package debug_pkg;

  localparam int DBG_WORD_W = 32;
  localparam int DBG_BYTE_W = 8;

  localparam logic [DBG_BYTE_W-1:0] DEF_HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEQ,
    DATA,
    CSUM
  } tx_state_e;

  // Header + sequence + 4 bytes per word + checksum.
  function automatic int frame_len(input int n);
    return 3 + 4 * n;
  endfunction

endpackage

// File: rtl/debug_period_timer.sv
// Free-running auto-trigger: one-cycle tick_o every PERIOD cycles from reset.
// Ports: clk, rst (async, active-high), tick_o (registered pulse).
module debug_period_timer #(
  parameter int PERIOD = 1024
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == LAST);
    cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/debug_frame_tx.sv
// Snapshots NUM_WORDS debug words on request and streams them as a
// framed byte sequence: HDR, seq, words MSB-first, XOR checksum.
// Ports: clk, rst (async, active-high), dbg_words_i, snap_req_i,
// tx_data_o/tx_vld_o/tx_rdy_i/tx_last_o (valid/ready byte port),
// busy_o, drop_cnt_o (saturating dropped-request count).
// Macro DEBUG_PERIODIC_EN adds an internal request every PERIOD cycles.
module debug_frame_tx
  import debug_pkg::*;
#(
  parameter int                    NUM_WORDS = 3,
  parameter logic [DBG_BYTE_W-1:0] HDR_BYTE  = DEF_HDR_BYTE,
  parameter int                    PERIOD    = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_WORDS*DBG_WORD_W-1:0] dbg_words_i,
  input  logic                            snap_req_i,
  output logic [DBG_BYTE_W-1:0]           tx_data_o,
  output logic                            tx_vld_o,
  input  logic                            tx_rdy_i,
  output logic                            tx_last_o,
  output logic                            busy_o,
  output logic [7:0]                      drop_cnt_o
);

  localparam int NB    = 4 * NUM_WORDS;
  localparam int IDX_W = $clog2(NB);
  localparam int SW    = NUM_WORDS * DBG_WORD_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

  tx_state_e             state_q, state_d;
  logic [DBG_BYTE_W-1:0] data_q, data_d;
  logic                  vld_q, vld_d;
  logic                  last_q, last_d;
  logic [DBG_BYTE_W-1:0] csum_q, csum_d;
  logic [7:0]            seq_q, seq_d;
  logic                  pend_q, pend_d;
  logic [7:0]            drop_q, drop_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [SW-1:0]         snap_q, snap_d;

  logic                  tick;
  logic                  req;
  logic                  xfer;
  logic [IDX_W-1:0]      idx_nx;
  logic [DBG_BYTE_W-1:0] byte_arr [NB];

`ifdef DEBUG_PERIODIC_EN
  debug_period_timer #(
    .PERIOD(PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick)
  );
`else
  logic unused_period;
  assign unused_period = |PERIOD;
  assign tick = 1'b0;
`endif

  // Byte k of the snapshot: word k/4, big-endian within the word.
  for (genvar k = 0; k < NB; k++) begin : g_byte
    assign byte_arr[k] =
      snap_q[(k/4)*32 + (3-(k%4))*8 +: 8];
  end

  assign req    = snap_req_i | tick;
  assign xfer   = vld_q & tx_rdy_i;
  assign idx_nx = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    vld_d   = vld_q;
    last_d  = last_q;
    csum_d  = csum_q;
    seq_d   = seq_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    idx_d   = idx_q;
    snap_d  = snap_q;

    unique case (state_q)
      IDLE: begin
        if (req | pend_q) begin
          state_d = HDR;
          snap_d  = dbg_words_i;
          vld_d   = 1'b1;
          data_d  = HDR_BYTE;
          last_d  = 1'b0;
          csum_d  = '0;
          idx_d   = '0;
          // A fresh request alongside a queued one stays queued.
          pend_d  = pend_q & req;
        end
      end
      HDR: begin
        if (xfer) begin
          state_d = SEQ;
          data_d  = seq_q;
          csum_d  = csum_q ^ data_q;
        end
      end
      SEQ: begin
        if (xfer) begin
          state_d = DATA;
          data_d  = byte_arr[0];
          idx_d   = '0;
          csum_d  = csum_q ^ data_q;
        end
      end
      DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ data_q;
          if (idx_q == IDX_LAST) begin
            state_d = CSUM;
            data_d  = csum_q ^ data_q;
            last_d  = 1'b1;
          end else begin
            idx_d  = idx_nx;
            data_d = byte_arr[idx_nx];
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          last_d  = 1'b0;
          data_d  = '0;
          seq_d   = seq_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // One-deep queue; overflow is counted, saturating.
    if (state_q != IDLE && req) begin
      if (!pend_q) begin
        pend_d = 1'b1;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      csum_q  <= '0;
      seq_q   <= '0;
      pend_q  <= 1'b0;
      drop_q  <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      csum_q  <= csum_d;
      seq_q   <= seq_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  assign tx_data_o  = data_q;
  assign tx_vld_o   = vld_q;
  assign tx_last_o  = last_q;
  assign busy_o     = (state_q != IDLE);
  assign drop_cnt_o = drop_q;

endmodule
